// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial program loader.
// Serves fetches in RUN and keeps the core in reset while a load is in progress.
module inst_rom_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_start_i,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_byte_i,
    output logic        ld_ready_o,
    output logic        ld_done_o,
    output logic        ld_err_o,
    output logic        cpu_rst_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        RUN,
        HDR,
        DATA,
        FIN
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [1:0]       bidx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] wcnt_inc;
    logic [23:0]      hold;
    logic [31:0]      word_full;
    logic [15:0]      hdr_count;
    logic             xfer;
    logic             last_word;
    logic             addr_hi_zero;
    logic             wr_en;
    logic             done_q;
    logic             err_q;
    logic             unused_ok;

    logic [31:0] mem [DEPTH];

    assign ld_ready_o   = (state == HDR) || (state == DATA);
    assign xfer         = ld_valid_i && ld_ready_o;
    assign word_full    = {hold, ld_byte_i};
    // Header is two bytes MSB first; the high byte waits in hold[7:0].
    assign hdr_count    = {hold[7:0], ld_byte_i};
    assign wcnt_inc     = wcnt + CNT_W'(1);
    assign last_word    = (bidx == 2'd3) && (wcnt_inc == count);
    assign addr_hi_zero = (addr_i[31:ADDR_W+2] == '0);
    assign ld_done_o    = done_q;
    assign ld_err_o     = err_q;
    assign cpu_rst_o    = rst || (state != RUN);
    assign unused_ok    = ^addr_i[1:0];

    // Word writes past the memory depth still count but are dropped.
    assign wr_en = (state == DATA) && xfer && !ld_start_i
                && (bidx == 2'd3)
                && ({{(32-CNT_W){1'b0}}, wcnt} < 32'(DEPTH));

    // Zero-latency fetch, blanked during loads and for out-of-range addresses.
    always_comb begin
        inst_o = 32'h0;
        if (ce_i && (state == RUN) && addr_hi_zero)
            inst_o = mem[addr_i[ADDR_W+1:2]];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_d;
    end

    // Next-state logic; a start request wins over any byte transfer.
    always_comb begin
        state_d = state;
        unique case (state)
            RUN: begin
                if (ld_start_i)
                    state_d = HDR;
            end
            HDR: begin
                if (ld_start_i)
                    state_d = HDR;
                else if (xfer && (bidx == 2'd1))
                    state_d = (hdr_count == 16'h0) ? FIN : DATA;
            end
            DATA: begin
                if (ld_start_i)
                    state_d = HDR;
                else if (xfer && last_word)
                    state_d = FIN;
            end
            FIN: begin
                state_d = ld_start_i ? HDR : RUN;
            end
        endcase
    end

    // Byte/word counters, header capture, byte assembly and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bidx   <= 2'd0;
            count  <= '0;
            wcnt   <= '0;
            hold   <= 24'h0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state_d == FIN);
            if (ld_start_i) begin
                bidx  <= 2'd0;
                count <= '0;
                wcnt  <= '0;
                hold  <= 24'h0;
                err_q <= 1'b0;
            end else if (xfer) begin
                if (state == HDR) begin
                    if (bidx == 2'd0) begin
                        hold[7:0] <= ld_byte_i;
                        bidx      <= 2'd1;
                    end else begin
                        count <= CNT_W'(hdr_count);
                        bidx  <= 2'd0;
                        if ({16'h0, hdr_count} > 32'(DEPTH))
                            err_q <= 1'b1;
                    end
                end else begin
                    hold <= {hold[15:0], ld_byte_i};
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3)
                        wcnt <= wcnt_inc;
                end
            end
        end
    end

    // Program memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wcnt[ADDR_W-1:0]] <= word_full;
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader.
// Fetch results go through a scoreboard queue; flags are checked directly.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic        ld_err_o;
    logic        cpu_rst_o;

    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;

    logic [31:0] exp_q [$];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    inst_rom_loader #(.ADDR_W(10), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_ready_o (ld_ready_o),
        .ld_done_o  (ld_done_o),
        .ld_err_o   (ld_err_o),
        .cpu_rst_o  (cpu_rst_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ld_done_o === 1'b1)
            done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic ce, input logic [31:0] a,
                         input logic [31:0] exp);
        logic [31:0] e;
        ce_i   = ce;
        addr_i = a;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("fetch@%h", a), inst_o, e);
        ce_i = 1'b0;
    endtask

    task automatic start();
        ld_start_i = 1'b1;
        cyc();
        ld_start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        while (!ld_ready_o && n < 20) begin
            cyc();
            n++;
        end
        if (!ld_ready_o) begin
            nvec++;
            nerr++;
            $display("FAIL ready_wait: act=0 exp=1");
        end
        cyc();
        ld_valid_i = 1'b0;
        if (gap)
            cyc();
    endtask

    task automatic send_basic(input bit gap);
        logic [7:0] s [10];
        s = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05,
              8'h3C, 8'h02, 8'hAB, 8'hCD};
        for (int i = 0; i < 10; i++)
            send(s[i], gap);
    endtask

    initial begin
        int d0;
        rst        = 1'b1;
        ce_i       = 1'b0;
        addr_i     = 32'h0;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i  = 8'h0;

        vecs[0] = '{1'b1, 32'h0000_0000, 32'h3401_0005};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h3C02_ABCD};
        vecs[2] = '{1'b1, 32'h0000_0007, 32'h3C02_ABCD};
        vecs[3] = '{1'b1, 32'h0000_0002, 32'h3401_0005};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h8000_0004, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h0000_1004, 32'h0000_0000};

        // reset state
        cyc();
        chk("cpu_rst_in_rst", 32'(cpu_rst_o), 32'd1);
        cyc();
        rst = 1'b0;
        #1;
        chk("cpu_rst_after", 32'(cpu_rst_o), 32'd0);
        chk("ready_reset", 32'(ld_ready_o), 32'd0);
        chk("done_reset", 32'(ld_done_o), 32'd0);
        chk("err_reset", 32'(ld_err_o), 32'd0);

        // valid in RUN is ignored
        ld_valid_i = 1'b1;
        ld_byte_i  = 8'hFF;
        cyc();
        ld_valid_i = 1'b0;
        chk("run_valid_ign", 32'(cpu_rst_o), 32'd0);

        // basic load with fetch blanked mid-DATA
        start();
        chk("cpu_rst_hdr", 32'(cpu_rst_o), 32'd1);
        chk("ready_hdr", 32'(ld_ready_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] p [6];
            p = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05};
            send(p[i], 1'b0);
        end
        fetch(1'b1, 32'h0, 32'h0);
        send(8'h3C, 1'b0);
        send(8'h02, 1'b0);
        send(8'hAB, 1'b0);
        chk("done_early", 32'(ld_done_o), 32'd0);
        send(8'hCD, 1'b0);
        chk("done_fin", 32'(ld_done_o), 32'd1);
        chk("cpu_rst_fin", 32'(cpu_rst_o), 32'd1);
        chk("ready_fin", 32'(ld_ready_o), 32'd0);
        cyc();
        chk("done_drop", 32'(ld_done_o), 32'd0);
        chk("cpu_rst_run", 32'(cpu_rst_o), 32'd0);

        for (int i = 0; i < 8; i++)
            fetch(vecs[i].ce, vecs[i].addr, vecs[i].exp);

        // restart after 6 data bytes
        start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        for (int i = 0; i < 6; i++)
            send((i < 4) ? 8'h11 : 8'h22, 1'b0);
        start();
        chk("ready_restart", 32'(ld_ready_o), 32'd1);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        chk("done_restart", 32'(ld_done_o), 32'd1);
        cyc();
        fetch(1'b1, 32'h0, 32'h5566_7788);
        fetch(1'b1, 32'h4, 32'h3C02_ABCD);

        // same stream with gaps
        start();
        send_basic(1'b1);
        cyc();
        fetch(1'b1, 32'h0, 32'h3401_0005);
        fetch(1'b1, 32'h4, 32'h3C02_ABCD);

        // zero-length header goes straight to FIN
        start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("done_zero", 32'(ld_done_o), 32'd1);
        cyc();
        fetch(1'b1, 32'h0, 32'h3401_0005);

        // reset mid-DATA
        d0 = done_cnt;
        start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hBE, 1'b0);
        send(8'hEF, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("cpu_rst_abort", 32'(cpu_rst_o), 32'd0);
        chk("ready_abort", 32'(ld_ready_o), 32'd0);
        repeat (4) cyc();
        chk("done_abort", 32'(done_cnt), 32'(d0));
        fetch(1'b1, 32'h0, 32'hDEAD_BEEF);
        fetch(1'b1, 32'h4, 32'h3C02_ABCD);

        // overflow: 1025 words into 1024 entries
        start();
        send(8'h04, 1'b0);
        chk("err_hdr1", 32'(ld_err_o), 32'd0);
        send(8'h01, 1'b0);
        chk("err_hdr2", 32'(ld_err_o), 32'd1);
        for (int w = 0; w < 1025; w++) begin
            logic [31:0] v;
            v = {16'hA5A5, 16'(w)};
            send(v[31:24], 1'b0);
            send(v[23:16], 1'b0);
            send(v[15:8], 1'b0);
            send(v[7:0], 1'b0);
        end
        chk("done_ovf", 32'(ld_done_o), 32'd1);
        cyc();
        repeat (3) cyc();
        fetch(1'b1, 32'h0, 32'hA5A5_0000);
        fetch(1'b1, 32'hFFC, 32'hA5A5_03FF);
        fetch(1'b1, 32'h200, 32'hA5A5_0080);
        chk("err_sticky", 32'(ld_err_o), 32'd1);
        start();
        chk("err_clear", 32'(ld_err_o), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
